i2c_reg_arbiter: RTL

Shares the single I2C byte controller (`i2c_master_byte_ctrl`) on the HDMI TX configuration bus between NREQ register-access requesters, for example the TX interrupt/power FSM and an EDID reader. Each requester issues complete register transactions:

- a write (dev, reg, data), or
- a random read (dev, reg -> data).

The block grants requesters round-robin, sequences the byte-level start/write/read/stop commands, checks every ACK, and returns read data plus an error status. It sits between the requesters and the byte controller; the byte controller stays instantiated outside.

---
 rtl/hdmi_i2c_pkg.sv | 59 +++++
 rtl/i2c_reg_arbiter_rr.sv | 42 ++++
 rtl/i2c_reg_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_i2c_pkg.sv
// Shared types and byte-command encodings for the HDMI TX I2C
// register-access path.
package hdmi_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEV_W,
        ST_REG,
        ST_WDATA,
        ST_DEV_R,
        ST_RDATA,
        ST_ABORT_STOP,
        ST_DONE
    } state_e;

    // Command bit order: {start, stop, read, write, ack_in}
    localparam logic [4:0] CMD_NONE     = 5'b00000;
    localparam logic [4:0] CMD_START_WR = 5'b10010;
    localparam logic [4:0] CMD_WR       = 5'b00010;
    localparam logic [4:0] CMD_WR_STOP  = 5'b01010;
    localparam logic [4:0] CMD_RD_NACK  = 5'b01101;
    localparam logic [4:0] CMD_STOP     = 5'b01000;

    localparam logic [6:0] TX_DEV_ADDR = 7'h39;

    function automatic logic [4:0] state_cmd(input state_e s);
        logic [4:0] c;
        c = CMD_NONE;
        unique case (s)
            ST_DEV_W:      c = CMD_START_WR;
            ST_REG:        c = CMD_WR;
            ST_WDATA:      c = CMD_WR_STOP;
            ST_DEV_R:      c = CMD_START_WR;
            ST_RDATA:      c = CMD_RD_NACK;
            ST_ABORT_STOP: c = CMD_STOP;
            default:       c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] state_din(
        input state_e     s,
        input logic [6:0] dev,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        logic [7:0] d;
        d = 8'h00;
        unique case (s)
            ST_DEV_W: d = {dev, 1'b0};
            ST_REG:   d = addr;
            ST_WDATA: d = wdata;
            ST_DEV_R: d = {dev, 1'b1};
            default:  d = 8'h00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_reg_arbiter_rr.sv
// Round-robin grant selection for the I2C register arbiter; the
// search starts one past the last granted requester.
module i2c_rr_arbiter
    import hdmi_i2c_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = (NREQ > 2) ? 2 : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] last_gnt_q;
    logic [IW-1:0] last_gnt_d;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_gnt_q) + k) % NREQ]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'((int'(last_gnt_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (take && gnt_valid) last_gnt_d = gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) last_gnt_q <= IW'(NREQ - 1);
        else       last_gnt_q <= last_gnt_d;
    end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Shares one I2C byte controller between NREQ register-access
// requesters: grants, sequences byte commands, checks ACKs.
module i2c_reg_arbiter
    import hdmi_i2c_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rnw,
    input  logic [7*NREQ-1:0] req_dev,
    input  logic [8*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              al,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              i2c_start,
    output logic              i2c_stop,
    output logic              i2c_read,
    output logic              i2c_write,
    output logic              i2c_ack_in,
    output logic [7:0]        i2c_din,
    input  logic              i2c_cmd_ack,
    input  logic              i2c_ack_out,
    input  logic [7:0]        i2c_dout,
    input  logic              i2c_al
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [4:0]      cmd_q, cmd_d;
    logic [7:0]      din_q, din_d;
    logic            issued_q, issued_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            al_q, al_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;

    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;
    logic            take;
    logic            cmd_done;
    logic            tmo_hit;

    assign take     = (state_q == ST_IDLE);
    assign cmd_done = (cmd_q != CMD_NONE) && i2c_cmd_ack;
    assign tmo_hit  = (cmd_q != CMD_NONE) && (tmo_q == TMO_LAST);

    i2c_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rnw_d    = rnw_q;
        dev_d    = dev_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cmd_d    = cmd_q;
        din_d    = din_q;
        issued_d = issued_q;
        tmo_d    = '0;
        done_d   = '0;
        err_d    = err_q;
        al_d     = al_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = ST_DEV_W;
                    gnt_d   = gnt_idx;
                    rnw_d   = req_rnw[gnt_idx];
                    dev_d   = req_dev[int'(gnt_idx)*7 +: 7];
                    addr_d  = req_reg[int'(gnt_idx)*8 +: 8];
                    wdata_d = req_wdata[int'(gnt_idx)*8 +: 8];
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    al_d    = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                tmo_d = tmo_q + 16'd1;
                if (i2c_al) begin
                    // Bus is no longer ours, so no stop is attempted.
                    cmd_d   = CMD_NONE;
                    err_d   = 1'b1;
                    al_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (cmd_done) begin
                    cmd_d = CMD_NONE;
                    unique case (state_q)
                        ST_DEV_W:
                            state_d = i2c_ack_out ? ST_ABORT_STOP : ST_REG;
                        ST_REG:
                            state_d = i2c_ack_out ? ST_ABORT_STOP
                                    : (rnw_q ? ST_DEV_R : ST_WDATA);
                        ST_WDATA:
                            state_d = i2c_ack_out ? ST_ABORT_STOP : ST_DONE;
                        ST_DEV_R:
                            state_d = i2c_ack_out ? ST_ABORT_STOP : ST_RDATA;
                        ST_RDATA: begin
                            rdata_d = i2c_dout;
                            state_d = ST_DONE;
                        end
                        default: state_d = ST_DONE;
                    endcase
                    if (i2c_ack_out && state_q != ST_RDATA
                        && state_q != ST_ABORT_STOP) err_d = 1'b1;
                end else if (tmo_hit) begin
                    cmd_d   = CMD_NONE;
                    err_d   = 1'b1;
                    state_d = (state_q == ST_ABORT_STOP) ? ST_DONE
                                                         : ST_ABORT_STOP;
                end else if (cmd_q == CMD_NONE && !issued_q) begin
                    cmd_d    = state_cmd(state_q);
                    din_d    = state_din(state_q, dev_q, addr_q, wdata_q);
                    issued_d = 1'b1;
                    tmo_d    = '0;
                end
            end
        endcase
        if (state_d != state_q) issued_d = 1'b0;
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d[gnt_q] = 1'b1;
            busy_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rnw_q    <= 1'b0;
            dev_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cmd_q    <= CMD_NONE;
            din_q    <= '0;
            issued_q <= 1'b0;
            tmo_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            al_q     <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rnw_q    <= rnw_d;
            dev_q    <= dev_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cmd_q    <= cmd_d;
            din_q    <= din_d;
            issued_q <= issued_d;
            tmo_q    <= tmo_d;
            done_q   <= done_d;
            err_q    <= err_d;
            al_q     <= al_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    assign {i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_in} = cmd_q;
    assign i2c_din = din_q;
    assign done    = done_q;
    assign err     = err_q;
    assign al      = al_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;

endmodule
